i2c_line_filter: RTL and testbench
==================================

// Module: i2c_line_filter
// PURPOSE
//  Input conditioning stage that sits between the SCL/SDA pads and the controller's scl_in/sda_in.
//  - Synchronises both lines to core_clk and removes glitches.
//  - Produces clean scl_f/sda_f, SCL edge strobes, START/STOP/repeated-START strobes and a bus-busy flag.
//  - Optional: arbitration-lost detection against the locally driven SDA.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser flops per line (>=2)
//  FILTER_LEN   4  consecutive stable samples required before a filtered line changes (>=1)
//  CNT_W        3  filter counter width; must satisfy 2**CNT_W > FILTER_LEN
// PORTS
//  core_clk    in   1  single clock for all logic
//  rst_n       in   1  asynchronous, active-low reset
//  scl_pad     in   1  raw SCL from pad
//  sda_pad     in   1  raw SDA from pad
//  sda_drv     in   1  SDA value this node drives (1 = released); used only with I2C_FILTER_ARB_LOST_EN
//  arb_clr     in   1  clears sticky arb_lost
//  scl_f       out  1  filtered SCL (to controller scl_in)
//  sda_f       out  1  filtered SDA (to controller sda_in / converter in)
//  scl_rise    out  1  1-cycle pulse: scl_f 0->1
//  scl_fall    out  1  1-cycle pulse: scl_f 1->0
//  start_det   out  1  1-cycle pulse: START or repeated START
//  rstart_det  out  1  1-cycle pulse: START while bus_busy (coincides with start_det)
//  stop_det    out  1  1-cycle pulse: STOP
//  bus_busy    out  1  high from START to STOP
//  arb_lost    out  1  sticky arbitration-lost flag
// BEHAVIOUR
//  Clocking/reset: one clock, core_clk; reset rst_n is asynchronous, active-low.
//  Reset values:
//  - Sync flops, scl_f, sda_f: 1 (idle bus).
//  - Counters, all pulses, bus_busy, arb_lost: 0.
//  Per-line filter (SCL and SDA independent):
//  - s = last sync stage. If s == filtered value, cnt <= 0.
//  - Otherwise cnt <= cnt+1. When cnt == FILTER_LEN-1 and s still differs: filtered <= s, cnt <= 0.
//  - A pulse shorter than FILTER_LEN cycles never reaches the output. Counter saturates; no wrap.
//  - Latency, pad edge to filtered edge: SYNC_STAGES + FILTER_LEN cycles, exactly.
//  Edge strobes:
//  - Compare scl_f with its 1-cycle delayed copy scl_q (reset 1) and sda_f with sda_q (reset 1).
//  - scl_rise = scl_f & ~scl_q; scl_fall = ~scl_f & scl_q.
//  - All strobes are registered and appear 1 cycle after the filtered edge.
//  Condition detect:
//  - START: sda_f 1->0 while scl_f==1 and scl_q==1.
//  - STOP: sda_f 0->1 while scl_f==1 and scl_q==1.
//  - SDA and SCL filtered edges in the same cycle produce neither START nor STOP.
//  Bus state FSM: IDLE, BUSY (bus_busy = state==BUSY).
//  - IDLE -START-> BUSY: start_det=1, rstart_det=0.
//  - BUSY -START-> BUSY: start_det=1, rstart_det=1.
//  - BUSY -STOP-> IDLE: stop_det=1.
//  - IDLE -STOP-> IDLE: stop_det=1, no state change.
//  Reset mid-transfer: everything returns to reset values immediately; the FSM re-arms on the next START.
// CONFIGURATION
//  Macro: I2C_FILTER_ARB_LOST_EN.
//  Defined:
//  - On scl_rise while bus_busy, if sda_drv==1 and sda_f==0, then arb_lost <= 1.
//  - arb_lost holds until arb_clr or stop_det; arb_clr wins over a same-cycle set.
//  Undefined:
//  - arb_lost tied to 0; sda_drv and arb_clr ignored; port list unchanged.
// TESTING
//  1 Reset: rst_n=0 mid-toggle -> scl_f=sda_f=1, all strobes 0, bus_busy=0 asynchronously.
//  2 Glitch: SDA low 3 cycles (FILTER_LEN=4), SCL high -> sda_f stays 1, no start_det;
//    4-cycle low -> sda_f falls exactly 6 cycles after the pad edge, start_det 1 cycle later.
//  3 Framing: START, 9 SCL pulses, STOP -> start_det x1, scl_rise x9, bus_busy 1 between strobes,
//    stop_det x1, bus_busy 0 next cycle.
//  4 Repeated START: START, 9 clocks, SCL high, SDA 1->0 -> start_det=rstart_det=1 same cycle, bus_busy stays 1.
//  5 Simultaneous: SDA and SCL pads change on the same core_clk edge -> no start_det/stop_det.
//  6 (I2C_FILTER_ARB_LOST_EN) sda_drv=1, pad SDA=0 at scl_rise while busy -> arb_lost=1;
//    arb_clr -> 0 next cycle; STOP also clears it. Without the macro -> arb_lost constant 0.

Source files
------------

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: SCL/SDA input conditioning.
// Each line is synchronised to core_clk and then glitch-filtered. The filtered
// lines drive SCL edge strobes, START/STOP/repeated-START detection and a
// bus-busy flag.
// Optional feature macro: I2C_FILTER_ARB_LOST_EN (sticky arbitration-lost flag).
// With the macro undefined, arb_lost is tied low and sda_drv/arb_clr are ignored.

// Per-line synchroniser plus stability filter.
module i2c_line_filter_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 3
) (
  input  logic core_clk,
  input  logic rst_n,
  input  logic pad,
  output logic filt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // Synchroniser chain; resets to 1 so an idle bus reads as released.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], pad};
  end

  // Only FILTER_LEN consecutive disagreeing samples move the filtered level.
  // The >= compare keeps the counter from wrapping if parameters are odd.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b1;
      cnt  <= '0;
    end else if (s == filt) begin
      cnt  <= '0;
    end else if (cnt >= CNT_LAST) begin
      filt <= s;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 3
) (
  input  logic core_clk,
  input  logic rst_n,
  input  logic scl_pad,
  input  logic sda_pad,
  input  logic sda_drv,
  input  logic arb_clr,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic rstart_det,
  output logic stop_det,
  output logic bus_busy,
  output logic arb_lost
);

  localparam int NUM_LINES = 2;  // [0] = SCL, [1] = SDA

  typedef enum logic {IDLE, BUSY} bus_st_t;

  logic [NUM_LINES-1:0] pads;
  logic [NUM_LINES-1:0] filt;
  logic                 scl_q, sda_q;
  logic                 start_c, stop_c;
  bus_st_t              state;

  assign pads  = {sda_pad, scl_pad};
  assign scl_f = filt[0];
  assign sda_f = filt[1];

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    i2c_line_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .CNT_W       (CNT_W)
    ) u_ch (
      .core_clk (core_clk),
      .rst_n    (rst_n),
      .pad      (pads[g]),
      .filt     (filt[g])
    );
  end

  // SDA edge while SCL has been high for at least two cycles. An SCL edge in
  // the same cycle breaks scl_q == scl_f, so coincident edges are ignored.
  always_comb begin
    start_c = scl_f & scl_q & sda_q & ~sda_f;
    stop_c  = scl_f & scl_q & ~sda_q & sda_f;
  end

  // Delayed copies of the filtered lines and registered SCL edge strobes.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
    end else begin
      scl_q    <= scl_f;
      sda_q    <= sda_f;
      scl_rise <= scl_f & ~scl_q;
      scl_fall <= ~scl_f & scl_q;
    end
  end

  // Bus state tracking with registered START/STOP strobes.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_det  <= 1'b0;
      rstart_det <= 1'b0;
      stop_det   <= 1'b0;
    end else begin
      start_det  <= 1'b0;
      rstart_det <= 1'b0;
      stop_det   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_c) begin
            state     <= BUSY;
            start_det <= 1'b1;
          end else if (stop_c) begin
            stop_det  <= 1'b1;
          end
        end
        BUSY: begin
          if (start_c) begin
            start_det  <= 1'b1;
            rstart_det <= 1'b1;
          end else if (stop_c) begin
            state    <= IDLE;
            stop_det <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_busy = (state == BUSY);

`ifdef I2C_FILTER_ARB_LOST_EN
  // Sticky arbitration loss: we released SDA but sampled it low on an SCL
  // rise. A clear request outranks a set in the same cycle.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n)                                           arb_lost <= 1'b0;
    else if (arb_clr || stop_det)                         arb_lost <= 1'b0;
    else if (scl_rise && bus_busy && sda_drv && !sda_f)   arb_lost <= 1'b1;
  end
`else
  logic unused_arb;
  assign unused_arb = &{1'b0, sda_drv, arb_clr};
  assign arb_lost   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_line_filter.sv
// Randomised and directed bench for i2c_line_filter against a behavioural model.
module tb_i2c_line_filter;

  localparam int SYNC = 2;
  localparam int FL   = 4;
  localparam int HL   = SYNC + FL;
`ifdef I2C_FILTER_ARB_LOST_EN
  localparam bit ARB_EN = 1'b1;
`else
  localparam bit ARB_EN = 1'b0;
`endif

  logic core_clk = 1'b0;
  logic rst_n    = 1'b0;
  logic scl_pad  = 1'b1, sda_pad = 1'b1, sda_drv = 1'b0, arb_clr = 1'b0;
  logic scl_f, sda_f, scl_rise, scl_fall, start_det, rstart_det, stop_det, bus_busy, arb_lost;

  int total = 0, bad = 0;

  i2c_line_filter dut (
    .core_clk(core_clk), .rst_n(rst_n), .scl_pad(scl_pad), .sda_pad(sda_pad),
    .sda_drv(sda_drv), .arb_clr(arb_clr), .scl_f(scl_f), .sda_f(sda_f),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det),
    .rstart_det(rstart_det), .stop_det(stop_det), .bus_busy(bus_busy), .arb_lost(arb_lost)
  );

  always #5 core_clk = ~core_clk;

  wire [8:0] dut_vec = {scl_f, sda_f, scl_rise, scl_fall, start_det, rstart_det,
                        stop_det, bus_busy, arb_lost};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Inputs seen by the DUT at each active edge.
  logic cap_scl, cap_sda, cap_drv, cap_clr;
  int   edge_cnt = 0;
  always @(posedge core_clk) begin
    if (rst_n) begin
      cap_scl  <= scl_pad;
      cap_sda  <= sda_pad;
      cap_drv  <= sda_drv;
      cap_clr  <= arb_clr;
      edge_cnt <= edge_cnt + 1;
    end
  end

  // Behavioural model: pad history, filtered levels as "last FL sampled
  // values all disagree", strobes from the filtered-level history.
  bit ph_scl[HL], ph_sda[HL];
  bit m_scl_f, m_sda_f, m_scl_q, m_sda_q;
  bit m_rise, m_fall, m_start, m_rstart, m_stop, m_busy, m_arb;

  function automatic bit flips(input bit h[HL], input bit cur);
    bit all_diff = 1'b1;
    for (int i = SYNC; i < SYNC + FL; i++) if (h[i] == cur) all_diff = 1'b0;
    return all_diff;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < HL; i++) begin ph_scl[i] = 1'b1; ph_sda[i] = 1'b1; end
    m_scl_f = 1; m_sda_f = 1; m_scl_q = 1; m_sda_q = 1;
    m_rise = 0; m_fall = 0; m_start = 0; m_rstart = 0; m_stop = 0; m_busy = 0; m_arb = 0;
  endtask

  task automatic model_step();
    bit st, sp, set_a, clr_a, nscl, nsda;
    for (int i = HL - 1; i > 0; i--) begin ph_scl[i] = ph_scl[i-1]; ph_sda[i] = ph_sda[i-1]; end
    ph_scl[0] = cap_scl;
    ph_sda[0] = cap_sda;
    st    = m_scl_f && m_scl_q && m_sda_q && !m_sda_f;
    sp    = m_scl_f && m_scl_q && !m_sda_q && m_sda_f;
    set_a = ARB_EN && m_rise && m_busy && cap_drv && !m_sda_f;
    clr_a = cap_clr || m_stop;
    if (ARB_EN) m_arb = clr_a ? 1'b0 : (set_a ? 1'b1 : m_arb);
    m_rise   = m_scl_f && !m_scl_q;
    m_fall   = !m_scl_f && m_scl_q;
    m_start  = st;
    m_rstart = st && m_busy;
    m_stop   = sp && !st;
    if (st) m_busy = 1'b1;
    else if (sp) m_busy = 1'b0;
    nscl = flips(ph_scl, m_scl_f) ? !m_scl_f : m_scl_f;
    nsda = flips(ph_sda, m_sda_f) ? !m_sda_f : m_sda_f;
    m_scl_q = m_scl_f; m_sda_q = m_sda_f;
    m_scl_f = nscl;    m_sda_f = nsda;
  endtask

  // Compare process: every cycle, midway between active edges.
  int seen_cnt = 0;
  initial begin
    model_reset();
    forever begin
      @(negedge core_clk);
      if (!rst_n) begin
        model_reset();
        seen_cnt = edge_cnt;
      end else if (edge_cnt != seen_cnt) begin
        seen_cnt = edge_cnt;
        model_step();
      end
      chk("cycle_outputs", dut_vec, {m_scl_f, m_sda_f, m_rise, m_fall, m_start, m_rstart,
                                     m_stop, m_busy, m_arb});
    end
  end

  // Strobe tallies gathered by the directed tests.
  int n_rise, n_start, n_stop, n_busy_bad;
  task automatic cyc();
    @(posedge core_clk);
    #1;
    if (scl_rise) begin n_rise++; if (!bus_busy) n_busy_bad++; end
    if (start_det) n_start++;
    if (stop_det) n_stop++;
  endtask

  task automatic clr_tally();
    n_rise = 0; n_start = 0; n_stop = 0; n_busy_bad = 0;
  endtask

  task automatic send_bit(input bit b);
    scl_pad = 0; repeat (3) cyc();
    sda_pad = b; repeat (3) cyc();
    scl_pad = 1; repeat (6) cyc();
  endtask

  task automatic do_start();
    sda_pad = 0; repeat (8) cyc();
  endtask

  task automatic do_stop();
    scl_pad = 0; repeat (3) cyc();
    sda_pad = 0; repeat (3) cyc();
    scl_pad = 1; repeat (6) cyc();
    sda_pad = 1; repeat (10) cyc();
  endtask

  initial begin
    int k, hs, hd;
    clr_tally();
    repeat (2) cyc();
    chk("reset_outputs", dut_vec, 9'b110000000);
    rst_n = 1'b1;
    repeat (4) cyc();

    // Random pad activity, including sub-filter glitches.
    hs = 0; hd = 0;
    for (int i = 0; i < 800; i++) begin
      if (hs == 0) begin scl_pad = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 8); end
      if (hd == 0) begin sda_pad = 1'($urandom_range(0, 1)); hd = $urandom_range(1, 8); end
      hs--; hd--;
      sda_drv = 1'($urandom_range(0, 1));
      arb_clr = ($urandom_range(0, 15) == 0);
      cyc();
    end
    arb_clr = 0; sda_drv = 0;

    // Asynchronous reset in the middle of toggling.
    scl_pad = 0; sda_pad = 0; repeat (5) cyc();
    scl_pad = 1; repeat (2) cyc();
    #2 rst_n = 1'b0;
    #1 chk("async_reset", dut_vec, 9'b110000000);
    scl_pad = 1; sda_pad = 1;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();

    // 3-cycle SDA glitch must not pass.
    clr_tally();
    sda_pad = 0; repeat (3) cyc();
    sda_pad = 1; repeat (12) cyc();
    chk("glitch_start_cnt", n_start, 0);
    chk("glitch_sda_f", sda_f, 1);

    // 4-cycle low passes with a fixed 6-cycle latency, START one cycle later.
    sda_pad = 0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin cyc(); if (!sda_f) begin k = i; break; end end
    chk("sda_fall_latency", k, SYNC + FL);
    cyc();
    chk("start_after_fall", start_det, 1);
    chk("start_not_rstart", rstart_det, 0);
    repeat (4) cyc();

    // Framing: 8 data bits plus ACK low, then STOP.
    clr_tally();
    for (int b = 0; b < 8; b++) send_bit(1'($urandom_range(0, 1)));
    send_bit(1'b0);
    sda_pad = 1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin cyc(); if (stop_det) begin k = i; break; end end
    chk("stop_latency", k, SYNC + FL + 1);
    cyc();
    chk("busy_after_stop", bus_busy, 0);
    chk("frame_rises", n_rise, 9);
    chk("frame_busy_on_rise", n_busy_bad, 0);
    chk("frame_stops", n_stop, 1);
    chk("frame_starts", n_start, 0);
    repeat (4) cyc();

    // Repeated START after 9 clocks with SDA high.
    do_start();
    for (int b = 0; b < 8; b++) send_bit(1'($urandom_range(0, 1)));
    send_bit(1'b1);
    sda_pad = 0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin cyc(); if (start_det) begin k = i; break; end end
    chk("rstart_seen", k, SYNC + FL + 1);
    chk("rstart_flag", rstart_det, 1);
    chk("rstart_busy", bus_busy, 1);
    do_stop();
    chk("rstart_idle_after_stop", bus_busy, 0);

    // Coincident SDA/SCL pad edges give no condition.
    clr_tally();
    scl_pad = 0; sda_pad = 0; repeat (12) cyc();
    scl_pad = 1; sda_pad = 1; repeat (12) cyc();
    chk("simul_starts", n_start, 0);
    chk("simul_stops", n_stop, 0);

    // Arbitration loss: released SDA seen low at SCL rise.
    sda_drv = 1;
    do_start();
    scl_pad = 0; repeat (6) cyc();
    scl_pad = 1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin cyc(); if (scl_rise) begin k = i; break; end end
    chk("arb_rise_seen", k, SYNC + FL + 1);
    cyc();
    chk("arb_set", arb_lost, ARB_EN);
    arb_clr = 1; cyc(); arb_clr = 0;
    chk("arb_cleared", arb_lost, 0);
    scl_pad = 0; repeat (6) cyc();
    scl_pad = 1; repeat (8) cyc();
    chk("arb_set_again", arb_lost, ARB_EN);
    sda_pad = 1; repeat (10) cyc();
    chk("arb_stop_clear", arb_lost, 0);
    chk("arb_bus_idle", bus_busy, 0);
    sda_drv = 0;
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
